// File: rtl/tx_hex_fmt.sv
// -----------------------------------------------------------------------------
// tx_hex_fmt
// Transmit-side formatter that sits between the debug command handlers and the
// UART transmitter.
//   type_tx=1 : the 32-bit word is sent as 8 uppercase ASCII hex characters,
//               most significant nibble first, followed by one SEP_CHAR byte.
//               With EMPTY_DASH=1 the "empty slot" word 32'hFFFF_FFFF is shown
//               as eight '-' characters instead of "FFFFFFFF".
//   type_tx=0 : dout[7:0] is sent as one raw byte (CR, LF, ...).
// ack_tx pulses for one cycle after the UART has accepted the last byte.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rstn     in   1   synchronous reset, active low
//   req_tx   in   1   request; dout/type_tx stable while high
//   type_tx  in   1   1 = hex word, 0 = raw byte
//   dout     in   32  data to send
//   ack_tx   out  1   one-cycle pulse: request fully transmitted
//   tx_data  out  8   byte to the UART transmitter
//   tx_vld   out  1   tx_data valid
//   tx_rdy   in   1   UART accepts tx_data when tx_vld & tx_rdy
//   busy     out  1   high whenever the FSM is not IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module tx_hex_fmt #(
  parameter logic [7:0] SEP_CHAR   = 8'h20,
  parameter bit         EMPTY_DASH = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout,
  output logic        ack_tx,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACK     = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;   // current nibble always sits in [31:28]
  logic        type_q,  type_d;
  logic        dash_q,  dash_d;    // latched "print as dashes" decision
  logic [3:0]  cnt_q,   cnt_d;     // characters still to be accepted
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_vld_q,  tx_vld_d;
  logic        ack_q,     ack_d;
  logic        busy_q,    busy_d;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  // Character to present, given the word aligned so its next nibble is on
  // top and the number of characters still outstanding (1 = separator).
  function automatic logic [7:0] char_gen(input logic [31:0] word,
                                          input logic        is_hex,
                                          input logic [3:0]  left,
                                          input logic        dash);
    logic [7:0] c;
    if (!is_hex) begin
      c = word[7:0];
    end else if (left == 4'd1) begin
      c = SEP_CHAR;
    end else if (dash) begin
      c = 8'h2D;
    end else begin
      c = hex_ascii(word[31:28]);
    end
    return c;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    type_d    = type_q;
    dash_d    = dash_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_tx) begin
          state_d   = SEND;
          shift_d   = dout;
          type_d    = type_tx;
          dash_d    = EMPTY_DASH && (dout == 32'hFFFF_FFFF);
          cnt_d     = type_tx ? 4'd9 : 4'd1;
          tx_vld_d  = 1'b1;
          tx_data_d = char_gen(dout, type_tx, type_tx ? 4'd9 : 4'd1,
                               EMPTY_DASH && (dout == 32'hFFFF_FFFF));
        end else begin
          tx_vld_d = 1'b0;
        end
      end
      SEND: begin
        if (tx_vld_q && tx_rdy) begin
          if (cnt_q == 4'd1) begin
            state_d   = ACK;
            tx_vld_d  = 1'b0;
            tx_data_d = 8'h00;
            cnt_d     = 4'd0;
            ack_d     = 1'b1;
          end else begin
            // Back-to-back: the next character is ready on the next cycle.
            shift_d   = {shift_q[27:0], 4'h0};
            cnt_d     = cnt_q - 4'd1;
            tx_data_d = char_gen({shift_q[27:0], 4'h0}, type_q,
                                 cnt_q - 4'd1, dash_q);
          end
        end else begin
          // Backpressure: hold the current character untouched.
          tx_vld_d = tx_vld_q;
        end
      end
      ACK: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        // A request left high after the ack must not start a new word.
        if (!req_tx) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_vld_d  = 1'b0;
        tx_data_d = 8'h00;
        cnt_d     = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shift_q   <= 32'h0000_0000;
      type_q    <= 1'b0;
      dash_q    <= 1'b0;
      cnt_q     <= 4'd0;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      type_q    <= type_d;
      dash_q    <= dash_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ack_tx  = ack_q;
  assign tx_data = tx_data_q;
  assign tx_vld  = tx_vld_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tx_hex_fmt.sv
module tb_tx_hex_fmt;

  logic        clk = 1'b0;
  logic        rstn, req_tx, type_tx, tx_rdy;
  logic [31:0] dout;
  logic        ack1, vld1, busy1, ack0, vld0, busy0;
  logic [7:0]  data1, data0;

  always #5 clk = ~clk;

  // dut1: dashes for the empty word, dut0: plain "FFFFFFFF"; both share inputs.
  tx_hex_fmt #(.SEP_CHAR(8'h20), .EMPTY_DASH(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx), .dout(dout),
    .ack_tx(ack1), .tx_data(data1), .tx_vld(vld1), .tx_rdy(tx_rdy), .busy(busy1));

  tx_hex_fmt #(.SEP_CHAR(8'h20), .EMPTY_DASH(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx), .dout(dout),
    .ack_tx(ack0), .tx_data(data0), .tx_vld(vld0), .tx_rdy(tx_rdy), .busy(busy0));

  int tests_run = 0;
  int fails     = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int ack_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int last_acc = -10;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d1, prev_d0;

  typedef struct {
    bit          typ;
    logic [31:0] d;
    int          stall_at;
    int          stall_len;
    bit          req_early;
    int          hold;
    int          exp_n;
    logic [7:0]  exp_first1;
    logic [7:0]  exp_first0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string h;
    h = "0123456789ABCDEF";
    return h[n];
  endfunction

  // Expected byte stream of one request for both DUT configurations.
  task automatic push_exp(input bit typ, input logic [31:0] d);
    if (!typ) begin
      q1.push_back(d[7:0]);
      q0.push_back(d[7:0]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        q1.push_back((d == 32'hFFFF_FFFF) ? 8'h2D : hexc(d[31-4*i -: 4]));
        q0.push_back(hexc(d[31-4*i -: 4]));
      end
      q1.push_back(8'h20);
      q0.push_back(8'h20);
    end
  endtask

  // Scoreboard / protocol monitor, sampling mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (prev_stall) begin
        chk("stall_vld_held", {31'd0, vld1}, 32'd1);
        chk("stall_data1_stable", {24'd0, data1}, {24'd0, prev_d1});
        chk("stall_data0_stable", {24'd0, data0}, {24'd0, prev_d0});
      end
      if (vld1 && tx_rdy) begin
        if (q1.size() == 0 || q0.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL extra_byte: got %h/%h expected no byte", data1, data0);
        end else begin
          chk("byte_dash", {24'd0, data1}, {24'd0, q1.pop_front()});
          chk("byte_nodash", {24'd0, data0}, {24'd0, q0.pop_front()});
        end
        acc_cnt++;
        last_acc = cyc;
      end
      if (ack1) begin
        ack_cnt++;
        chk("ack_without_vld", {31'd0, vld1}, 32'd0);
        chk("ack_latency", cyc, last_acc + 1);
        chk("ack_nodash", {31'd0, ack0}, 32'd1);
      end
    end
    prev_stall = rstn && vld1 && !tx_rdy;
    prev_d1    = data1;
    prev_d0    = data0;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},  {31'd0, ack1},  32'd0);
    chk({tag, "_vld"},  {31'd0, vld1},  32'd0);
    chk({tag, "_data"}, {24'd0, data1}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, "_vld0"}, {31'd0, vld0},  32'd0);
    chk({tag, "_busy0"},{31'd0, busy0}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int stall_left;
    base       = ack_cnt;
    acc_cnt    = 0;
    stall_left = v.stall_len;
    push_exp(v.typ, v.d);
    @(posedge clk); #1;
    req_tx  = 1'b1;
    type_tx = v.typ;
    dout    = v.d;
    tx_rdy  = 1'b0;
    @(negedge clk); #1;
    chk("idle_no_vld", {31'd0, vld1}, 32'd0);
    for (int c = 0; c < 200 && ack_cnt == base; c++) begin
      @(posedge clk); #1;
      if (v.req_early && acc_cnt >= 1) req_tx = 1'b0;
      if (acc_cnt == v.stall_at && stall_left > 0) begin
        tx_rdy = 1'b0;
        stall_left--;
      end else begin
        tx_rdy = 1'b1;
      end
      @(negedge clk); #1;
      if (c == 0) begin
        chk("first_vld", {31'd0, vld1}, 32'd1);
        chk("first_busy", {31'd0, busy1}, 32'd1);
        chk("first_char_dash", {24'd0, data1}, {24'd0, v.exp_first1});
        chk("first_char_nodash", {24'd0, data0}, {24'd0, v.exp_first0});
      end
    end
    if (ack_cnt == base) begin
      tests_run++;
      fails++;
      $display("FAIL ack_timeout: got no ack expected one within 200 cycles");
    end
    // Request left high after the ack: no restart, stay busy.
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("sticky_no_vld", {31'd0, vld1}, 32'd0);
      chk("sticky_busy", {31'd0, busy1}, 32'd1);
    end
    @(posedge clk); #1;
    req_tx = 1'b0;
    for (int w = 0; w < 10 && busy1; w++) begin
      @(negedge clk); #1;
    end
    chk("busy_clear", {31'd0, busy1}, 32'd0);
    @(negedge clk); #1;
    chk("one_ack", ack_cnt, base + 1);
    chk("byte_count", acc_cnt, v.exp_n);
    chk("queue_drained", q1.size() + q0.size(), 0);
  endtask

  initial begin
    vec_t vt[$];
    vec_t rv;
    int   base;
    vt.push_back('{1'b0, 32'h0000_000D, -1, 0, 1'b0, 0, 1, 8'h0D, 8'h0D});
    vt.push_back('{1'b1, 32'h1234_ABCD, -1, 0, 1'b0, 0, 9, 8'h31, 8'h31});
    vt.push_back('{1'b1, 32'hFFFF_FFFF, -1, 0, 1'b0, 0, 9, 8'h2D, 8'h46});
    vt.push_back('{1'b1, 32'h1234_ABCD,  2, 3, 1'b0, 0, 9, 8'h31, 8'h31});
    vt.push_back('{1'b1, 32'h89AB_CDEF, -1, 0, 1'b0, 5, 9, 8'h38, 8'h38});
    vt.push_back('{1'b0, 32'hFFFF_FFFF, -1, 0, 1'b0, 0, 1, 8'hFF, 8'hFF});
    vt.push_back('{1'b1, 32'h0000_0000,  0, 2, 1'b0, 0, 9, 8'h30, 8'h30});
    vt.push_back('{1'b1, 32'hFFFF_FFFE,  8, 2, 1'b1, 0, 9, 8'h46, 8'h46});
    vt.push_back('{1'b0, 32'h1234_560A,  0, 3, 1'b0, 0, 1, 8'h0A, 8'h0A});

    rstn = 1'b0; req_tx = 1'b0; type_tx = 1'b0; dout = 32'h0; tx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Reset one clock after the 4th character is accepted: word abandoned.
    base    = ack_cnt;
    acc_cnt = 0;
    push_exp(1'b1, 32'h1234_ABCD);
    @(posedge clk); #1;
    req_tx = 1'b1; type_tx = 1'b1; dout = 32'h1234_ABCD; tx_rdy = 1'b1;
    for (int c = 0; c < 50 && acc_cnt < 4; c++) begin
      @(negedge clk); #1;
    end
    chk("pre_reset_bytes", acc_cnt, 4);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_zero("midword_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    req_tx = 1'b0;
    q1.delete();
    q0.delete();
    repeat (5) @(negedge clk);
    #1;
    chk("reset_no_ack", ack_cnt, base);
    chk("reset_no_more_bytes", acc_cnt, 4);
    chk("reset_idle_busy", {31'd0, busy1}, 32'd0);

    // Fresh request after the reset must come out complete.
    rv = '{1'b1, 32'h5A6B_7C8D, -1, 0, 1'b0, 0, 9, 8'h35, 8'h35};
    run_vec(rv);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
